bsg_mesh_link_credit_arb: RTL and testbench

Round-robin, credit-based output arbiter for one outgoing link of a `bsg_mesh_router`-style mesh tile. It accepts single-flit packets from up to `num_in_p` requesting input ports (P/W/E/N/S). Each cycle it selects at most one winner and registers that flit onto the link. It tracks downstream buffer space with a credit counter, so the link never overruns the neighbour's `bsg_fifo_1r1w_small`.

---
 rtl/bsg_mesh_link_credit_arb.sv | 113 +++++++++++
 tb/tb_bsg_mesh_link_credit_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bsg_mesh_link_credit_arb.sv
// Round-robin, credit-based output arbiter for one mesh link: picks at most one
// single-flit packet per cycle, registers it onto the link, and tracks downstream space.
module bsg_mesh_link_credit_arb #(
  parameter int num_in_p        = 5,
  parameter int width_p         = 8,
  parameter int credits_p       = 4,
  localparam int credit_width_lp = $clog2(credits_p + 1),
  localparam int ptr_width_lp    = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_in_p-1:0]           v_i,
  input  logic [num_in_p*width_p-1:0]   data_i,
  output logic [num_in_p-1:0]           yumi_o,
  output logic                          link_v_o,
  output logic [width_p-1:0]            link_data_o,
  input  logic                          credit_i,
  output logic [credit_width_lp-1:0]    credits_o,
  output logic                          credit_overflow_o,
  output logic [ptr_width_lp-1:0]       ptr_o
);

  // Handshake: input k offers a flit while v_i[k] is high; yumi_o[k] pulses in the
  // cycle the flit is taken (valid-then-yumi, so yumi never rises without v_i[k]).
  // The upstream may drop or change its flit only after a yumi.

  localparam logic [credit_width_lp-1:0] credits_full_lp = credit_width_lp'(credits_p);

  logic [ptr_width_lp-1:0]    ptr_q, ptr_d;
  logic [credit_width_lp-1:0] credits_q, credits_d;
  logic                       link_v_q, link_v_d;
  logic [width_p-1:0]         link_data_q, link_data_d;
  logic                       overflow_q, overflow_d;

  logic                       found;
  logic [ptr_width_lp-1:0]    winner;
  logic [ptr_width_lp-1:0]    idx;
  logic                       grant;
  int                         scan;

  // Scan from ptr upward with wrap; the first valid input wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    scan   = 0;
    for (int i = 0; i < num_in_p; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= num_in_p) scan = scan - num_in_p;
      idx = ptr_width_lp'(scan);
      if (!found && v_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // credit_i is deliberately absent here: a returned credit is usable next cycle.
  assign grant = found && (credits_q != '0) && !reset_i;

  always_comb begin
    yumi_o = '0;
    for (int k = 0; k < num_in_p; k++) begin
      yumi_o[k] = grant && (winner == ptr_width_lp'(k));
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    credits_d   = credits_q;
    link_v_d    = 1'b0;
    link_data_d = link_data_q;
    overflow_d  = overflow_q;

    if (grant) begin
      ptr_d       = (winner == ptr_width_lp'(num_in_p - 1)) ? '0 : winner + 1'b1;
      link_v_d    = 1'b1;
      link_data_d = data_i[winner*width_p +: width_p];
    end

    case ({grant, credit_i})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01: begin
        if (credits_q == credits_full_lp) overflow_d = 1'b1;
        else                              credits_d  = credits_q + 1'b1;
      end
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q       <= '0;
      credits_q   <= credits_full_lp;
      link_v_q    <= 1'b0;
      link_data_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      credits_q   <= credits_d;
      link_v_q    <= link_v_d;
      link_data_q <= link_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign link_v_o          = link_v_q;
  assign link_data_o       = link_data_q;
  assign credits_o         = credits_q;
  assign credit_overflow_o = overflow_q;
  assign ptr_o             = ptr_q;

endmodule

// File: tb/tb_bsg_mesh_link_credit_arb.sv
// Directed and randomized bench for bsg_mesh_link_credit_arb against a behavioural
// round-robin/credit model with an expected-flit queue.
module tb_bsg_mesh_link_credit_arb;

  localparam int N = 5;
  localparam int W = 8;
  localparam int C = 4;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   v_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   yumi_o;
  logic           link_v_o;
  logic [W-1:0]   link_data_o;
  logic           credit_i = 1'b0;
  logic [2:0]     credits_o;
  logic           credit_overflow_o;
  logic [2:0]     ptr_o;

  bsg_mesh_link_credit_arb #(.num_in_p(N), .width_p(W), .credits_p(C)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .link_v_o(link_v_o), .link_data_o(link_data_o), .credit_i(credit_i),
    .credits_o(credits_o), .credit_overflow_o(credit_overflow_o), .ptr_o(ptr_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         m_ptr, m_cred, m_ovf, m_lv;
  logic [W-1:0] m_ld;
  logic [W-1:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         grant_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_cred = C; m_ovf = 0; m_lv = 0; m_ld = '0;
    exp_q.delete();
  endtask

  task automatic do_cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                          input logic c, input logic rst);
    int win;
    logic [N-1:0] exp_yumi;
    logic [W-1:0] flit;
    v_i = v; data_i = d; credit_i = c; reset_i = rst;
    #1;
    win = -1;
    if (!rst && m_cred > 0) begin
      for (int i = 0; i < N; i++) begin
        if (win < 0 && v[(m_ptr + i) % N]) win = (m_ptr + i) % N;
      end
    end
    exp_yumi = '0;
    if (win >= 0) exp_yumi[win] = 1'b1;
    chk("yumi", 32'(yumi_o), 32'(exp_yumi));

    if (rst) begin
      model_reset();
    end else begin
      m_lv = 0;
      if (win >= 0) begin
        flit = d[win*W +: W];
        exp_q.push_back(flit);
        grant_log.push_back(win);
        m_ld  = flit;
        m_lv  = 1;
        m_ptr = (win + 1) % N;
      end
      if (win >= 0 && !c)                 m_cred = m_cred - 1;
      else if (win < 0 && c && m_cred == C) m_ovf = 1;
      else if (win < 0 && c)               m_cred = m_cred + 1;
    end

    @(posedge clk); #1;
    chk("link_v", 32'(link_v_o), 32'(m_lv));
    if (link_v_o === 1'b1 && exp_q.size() > 0) begin
      flit = exp_q.pop_front();
      chk("link_data_flit", 32'(link_data_o), 32'(flit));
    end else begin
      chk("link_data_hold", 32'(link_data_o), 32'(m_ld));
    end
    chk("credits", 32'(credits_o), 32'(m_cred));
    chk("overflow", 32'(credit_overflow_o), 32'(m_ovf));
    chk("ptr", 32'(ptr_o), 32'(m_ptr));
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom_range(0, 255));
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] d;
    model_reset();

    // Reset state, with requests present to show yumi is suppressed.
    do_cycle(5'b11111, rand_data(), 1'b0, 1'b1);
    do_cycle(5'b00000, '0, 1'b0, 1'b1);

    // Single requester, no returns: four grants, then starvation.
    d = '0; d[2*W +: W] = 8'hA5;
    for (int i = 0; i < 6; i++) do_cycle(5'b00100, d, 1'b0, 1'b0);
    chk("starved_credits", 32'(credits_o), 32'd0);
    // Credit at zero: no grant this cycle, grant the next.
    do_cycle(5'b00100, d, 1'b1, 1'b0);
    do_cycle(5'b00100, d, 1'b0, 1'b0);

    // Refill to full, then one extra credit overflows.
    for (int i = 0; i < 5; i++) do_cycle(5'b00000, d, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) do_cycle(5'b00000, d, 1'b0, 1'b0);
    chk("overflow_sticky", 32'(credit_overflow_o), 32'd1);

    // Fairness: everyone valid, a credit every cycle.
    do_cycle('0, '0, 1'b0, 1'b1);
    grant_log.delete();
    for (int i = 0; i < 12; i++) do_cycle(5'b11111, rand_data(), 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) chk("rr_order", 32'(grant_log[i]), 32'(i % N));

    // Pointer skip and wrap.
    do_cycle('0, '0, 1'b0, 1'b1);
    do_cycle(5'b01000, rand_data(), 1'b1, 1'b0);
    do_cycle(5'b00011, rand_data(), 1'b1, 1'b0);
    chk("wrap_ptr1", 32'(ptr_o), 32'd1);
    do_cycle(5'b00011, rand_data(), 1'b1, 1'b0);
    chk("wrap_ptr2", 32'(ptr_o), 32'd2);

    // Grant and credit together at one credit.
    do_cycle('0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(5'b00001, rand_data(), 1'b0, 1'b0);
    do_cycle(5'b00001, rand_data(), 1'b1, 1'b0);
    chk("grant_and_credit", 32'(credits_o), 32'd1);

    // Reset mid-stream with a flit on the link and two credits.
    do_cycle('0, '0, 1'b0, 1'b1);
    do_cycle(5'b10000, rand_data(), 1'b0, 1'b0);
    do_cycle(5'b10000, rand_data(), 1'b0, 1'b0);
    do_cycle(5'b10000, rand_data(), 1'b1, 1'b1);
    chk("reset_mid_link_v", 32'(link_v_o), 32'd0);
    grant_log.delete();
    do_cycle(5'b10110, rand_data(), 1'b0, 1'b0);
    chk("first_after_reset", 32'(grant_log[0]), 32'd1);

    // Random traffic with occasional resets and surplus credits.
    for (int i = 0; i < 400; i++) begin
      do_cycle(N'($urandom_range(0, 31)), rand_data(),
               ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
